bitstuff_block: RTL and testbench
=================================

# bitstuff_block

USB 2.0 transmit-path bit stuffer in the Serial Interface Engine. It takes the serial NRZ bit stream from the parallel-to-serial stage and inserts a 0 after every run of six consecutive 1s. Its output feeds the NRZI encoder. It also raises a stall flag so the upstream serializer holds its bit for one cycle while the stuffed zero is emitted.

## Interface
Parameters: none (run length fixed at 6 per USB 2.0).

Ports:
- CLK  in  1  bit clock; all state changes on its rising edge.
- RST  in  1  reset, asynchronous, active-low.
- EnData  in  1  stream enable; 1 = a bit is offered on Data_in this cycle.
- Data_in  in  1  NRZ data bit from the serializer.
- Stuffed  out  1  stall flag; 1 = the next edge emits a stuffed 0 and ignores Data_in. Upstream must hold Data_in.
- Data_out  out  1  registered, stuffed NRZ bit to the NRZI encoder.

## Operation
- Internal state: ones counter `cnt`, 3 bits, range 0..6. It counts consecutive 1s already driven on Data_out.
- Stuffed = (cnt == 6). This is a Moore output decoded from the register, with no combinational path from any input.
- Rising edge with EnData=1 and cnt==6 (stuff cycle):
  - Data_out <= 0.
  - cnt <= 0.
  - Data_in is not consumed.
- Rising edge with EnData=1 and cnt<6 (normal cycle):
  - Data_out <= Data_in.
  - cnt <= Data_in ? cnt+1 : 0.
- Rising edge with EnData=0:
  - Data_out holds its value.
  - cnt <= 0, so Stuffed drops to 0.
  - A stuff pending when EnData falls is discarded; the packet has ended.
- The stuff is inserted after the sixth 1 whatever the next data bit is. A sixth 1 followed by a natural 0 still yields 1,0,0.
- The stuffed 0 resets the run. A stream of N consecutive 1s produces a stuffed 0 after each group of six.
- cnt never exceeds 6; no wrap-around is possible.
- Data_in = X during a stuff cycle or while EnData=0 must not propagate to Data_out.

## Timing
- Reset (RST=0, asynchronous, at any time including mid-packet):
  - Data_out = 0, cnt = 0, Stuffed = 0, immediately.
  - The first edge after RST rises behaves as a normal cycle.
- Latency Data_in -> Data_out: 1 clock on normal cycles.
- Stuffed rises in the same cycle that the sixth consecutive 1 appears on Data_out. It stays high for exactly one cycle.
  - The following edge drives the stuffed 0, and Stuffed falls.
  - The bit held by upstream is consumed on the edge after that.
- Throughput: 6 data bits per 7 output cycles for all-ones data; 1 bit/cycle otherwise.
- Stuffed is never high for two consecutive cycles.

## Test plan
- Reset: drive RST=0 with Data_in=X, EnData=1 -> Data_out=0 and Stuffed=0 throughout. Release RST, then drive 1,0 -> Data_out 1,0 one cycle later each.
- Single run, upstream honours stall: EnData=1, Data_in = 0, then seven 1s with the 7th held through the Stuffed cycle -> Data_out 0,1,1,1,1,1,1,0,1. Stuffed=1 only in the cycle the 6th 1 is on Data_out.
- Long run of 20 1s honouring stalls -> Data_out 111111 0 111111 0 111111 0 11. Stuffed is asserted exactly 3 times, each for one cycle.
- Boundary cases:
  - Five 1s then a 0 -> Data_out 11111 0, Stuffed never asserted.
  - Six 1s then a 0 -> Data_out 111111 0 0 (stuff plus the real 0).
- Enable and reset interrupts:
  - Drive five 1s, EnData=0 for one cycle, then 1,1 -> no stuff, cnt restarts, Data_out holds during the EnData=0 cycle.
  - Assert RST mid-run after four 1s -> cnt cleared. Six further 1s are then needed before Stuffed rises.
- Free-running source that ignores Stuffed (Data_in changes every cycle): 1,0, then 31 ones, then 0 -> a 0 is inserted after every sixth 1. Data_in presented on stuff edges is dropped, and Data_out never carries seven consecutive 1s.

Source files
------------

// File: rtl/bitstuff_block_if.sv
// Serial stream between the serializer, the bit stuffer and the NRZI encoder.
// master: upstream serializer side; slave: the bit stuffer.
interface bitstuff_block_if;
    logic EnData;
    logic Data_in;
    logic Stuffed;
    logic Data_out;

    modport master (
        output EnData,
        output Data_in,
        input  Stuffed,
        input  Data_out
    );

    modport slave (
        input  EnData,
        input  Data_in,
        output Stuffed,
        output Data_out
    );
endinterface

// File: rtl/bitstuff_block.sv
// USB 2.0 transmit bit stuffer: inserts a 0 after every six consecutive 1s on
// the NRZ stream and stalls the serializer for the cycle the 0 is emitted.
module bitstuff_block (
    input  logic            CLK,
    input  logic            RST,
    bitstuff_block_if.slave bus
);
    // Number of consecutive 1s already driven on Data_out (0..6).
    logic [2:0] cnt_q, cnt_d;
    logic       data_q, data_d;
    logic       stuff;

    // Moore decode: a stuff is due once six 1s have gone out.
    assign stuff        = (cnt_q == 3'd6);
    assign bus.Stuffed  = stuff;
    assign bus.Data_out = data_q;

    // Next state: stuff cycles ignore Data_in; a gap in the stream drops any pending stuff.
    always_comb begin
        cnt_d  = 3'd0;
        data_d = data_q;
        if (bus.EnData) begin
            if (stuff) begin
                data_d = 1'b0;
                cnt_d  = 3'd0;
            end else begin
                data_d = bus.Data_in;
                cnt_d  = bus.Data_in ? (cnt_q + 3'd1) : 3'd0;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q  <= 3'd0;
            data_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end
endmodule

// File: tb/tb_bitstuff_block.sv
// Directed bench for bitstuff_block: expected Data_out/Stuffed pairs are queued
// as each bit is driven and popped after the clock edge that produces them.
module tb_bitstuff_block;
    logic CLK;
    logic RST;

    bitstuff_block_if bus ();

    bitstuff_block dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic d;
        logic s;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass;
    int   n_checks;
    logic last_d;
    int   stuff_seen;
    int   max_run;
    int   run;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive up to n bits (MSB first) for m cycles. With honour set, a bit offered
    // while Stuffed is high is held and re-offered on the next cycle.
    task automatic feed(input string tag, input logic [63:0] bits, input int n,
                        input bit honour, input logic [63:0] exp_d,
                        input logic [63:0] exp_s, input int m);
        int   idx;
        logic prev_s;
        exp_t e;
        idx    = 0;
        prev_s = 1'b0;
        for (int k = 0; k < m; k++) begin
            bus.EnData  = 1'b1;
            bus.Data_in = (idx < n) ? bits[n-1-idx] : 1'b0;
            if (!honour || !bus.Stuffed) idx++;
            exp_q.push_back('{d: exp_d[m-1-k], s: exp_s[m-1-k]});
            last_d = exp_d[m-1-k];
            @(posedge CLK);
            #1;
            e = exp_q.pop_front();
            chk({tag, "_dout"}, 32'(bus.Data_out), 32'(e.d));
            chk({tag, "_stuffed"}, 32'(bus.Stuffed), 32'(e.s));
            if (bus.Stuffed) stuff_seen++;
            if (prev_s && bus.Stuffed) chk({tag, "_stuff_twice"}, 32'(1), 32'(0));
            prev_s = bus.Stuffed;
            run = bus.Data_out ? run + 1 : 0;
            if (run > max_run) max_run = run;
        end
    endtask

    // One cycle with EnData low: Data_out must hold, Stuffed must be low.
    task automatic idle(input string tag);
        exp_t e;
        bus.EnData  = 1'b0;
        bus.Data_in = 1'bx;
        exp_q.push_back('{d: last_d, s: 1'b0});
        @(posedge CLK);
        #1;
        e = exp_q.pop_front();
        chk({tag, "_hold"}, 32'(bus.Data_out), 32'(e.d));
        chk({tag, "_nostuff"}, 32'(bus.Stuffed), 32'(e.s));
    endtask

    initial begin
        n_pass     = 0;
        n_checks   = 0;
        last_d     = 1'b0;
        stuff_seen = 0;
        max_run    = 0;
        run        = 0;

        // Reset held with garbage input.
        RST         = 1'b0;
        bus.EnData  = 1'b1;
        bus.Data_in = 1'bx;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            chk("rst_dout", 32'(bus.Data_out), 32'(0));
            chk("rst_stuffed", 32'(bus.Stuffed), 32'(0));
        end
        @(negedge CLK);
        RST = 1'b1;
        feed("post_rst", 64'(2'b10), 2, 1'b1, 64'(2'b10), 64'(2'b00), 2);
        idle("gap0");

        // 0 then seven 1s, seventh held through the stuff.
        feed("run7", 64'(8'b0111_1111), 8, 1'b1,
             64'(9'b0_1111_1101), 64'(9'b0_0000_0100), 9);
        idle("gap1");

        // 20 ones: three stuffs.
        stuff_seen = 0;
        feed("run20", 64'(20'hF_FFFF), 20, 1'b1,
             64'(23'b111111_0_111111_0_111111_0_11),
             64'(23'b000001_0_000001_0_000001_0_00), 23);
        chk("run20_stuff_count", 32'(stuff_seen), 32'(3));
        idle("gap2");

        // Five 1s then 0: no stuff.
        feed("five", 64'(6'b111110), 6, 1'b1, 64'(6'b111110), 64'(6'b000000), 6);
        idle("gap3");

        // Six 1s then 0: stuffed 0 plus the real 0.
        feed("six", 64'(7'b1111110), 7, 1'b1, 64'(8'b11111100), 64'(8'b00000100), 8);
        idle("gap4");

        // Five 1s, enable gap, then the count restarts from zero.
        feed("en_a", 64'(5'b11111), 5, 1'b1, 64'(5'b11111), 64'(5'b00000), 5);
        idle("en_gap");
        feed("en_b", 64'(6'b111111), 6, 1'b1, 64'(7'b1111110), 64'(7'b0000010), 7);
        idle("gap5");

        // Four 1s, asynchronous reset mid-cycle, then six more 1s needed.
        feed("rst_a", 64'(4'b1111), 4, 1'b1, 64'(4'b1111), 64'(4'b0000), 4);
        #2;
        RST = 1'b0;
        #1;
        chk("async_rst_dout", 32'(bus.Data_out), 32'(0));
        chk("async_rst_stuffed", 32'(bus.Stuffed), 32'(0));
        @(negedge CLK);
        RST    = 1'b1;
        last_d = 1'b0;
        run    = 0;
        feed("rst_b", 64'(6'b111111), 6, 1'b1, 64'(7'b1111110), 64'(7'b0000010), 7);
        idle("gap6");

        // Free-running source ignoring Stuffed: bits offered on stuff edges are lost.
        max_run = 0;
        run     = 0;
        feed("free", 64'({2'b10, 31'h7FFF_FFFF, 1'b0}), 34, 1'b0,
             64'({2'b10, 7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110, 4'b1110}),
             64'({2'b00, 7'b0000010, 7'b0000010, 7'b0000010, 7'b0000010, 4'b0000}), 34);
        chk("free_max_run", 32'(max_run), 32'(6));
        chk("sb_empty", 32'(exp_q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
